ws_frame_sequencer: RTL and testbench

- Parametrised successor to the fixed-size pattern-animation top logic.
- Generates one WS2811 frame per update tick: reads UNITS_NUMBER colours from a pattern ROM, applies brightness scaling and feeds a WS2811 transmitter through a start/busy handshake.
- Accepts decoded user commands: pause, direction, pattern select, speed and brightness.
- Sits between the command decoder (IR or other), the pattern ROM and the transmitter.

---
 rtl/ws_frame_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_ws_frame_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_frame_sequencer.sv
// ws_frame_sequencer: per-tick WS2811 frame generator that reads a pattern ROM,
// scales brightness and drives the transmitter over a start/busy handshake.
module ws_frame_sequencer #(
    parameter int CLOCK_SPEED           = 50_000_000,
    parameter int UPDATES_PER_SECOND    = 20,
    parameter int UNITS_NUMBER          = 100,
    parameter int PATTERN_COLORS_NUMBER = 128,
    parameter int PATTERNS_NUMBER       = 4,
    parameter int ROM_LATENCY           = 1,
    parameter int MAX_STEP              = 4,
    localparam int PW = $clog2(PATTERNS_NUMBER),
    localparam int CW = $clog2(PATTERN_COLORS_NUMBER)
) (
    input  logic             clkIN,
    input  logic             nResetIN,
    input  logic             cmdValidIN,
    input  logic [2:0]       cmdIN,
    output logic [PW+CW-1:0] romAddrOUT,
    input  logic [23:0]      romDataIN,
    output logic [23:0]      txDataOUT,
    output logic             txStartOUT,
    input  logic             txBusyIN,
    output logic             frameActiveOUT,
    output logic             pausedOUT,
    output logic [PW-1:0]    patternIndexOUT
);

    localparam int PERIOD = CLOCK_SPEED / UPDATES_PER_SECOND;
    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int SW = $clog2(MAX_STEP + 1);
    localparam int UW = (UNITS_NUMBER > 1) ? $clog2(UNITS_NUMBER) : 1;
    localparam int LW = $clog2(ROM_LATENCY + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(PERIOD - 1);
    localparam logic [SW-1:0] STEP_MAX  = SW'(MAX_STEP);
    localparam logic [SW-1:0] STEP_MIN  = SW'(1);
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNITS_NUMBER - 1);
    localparam logic [LW-1:0] WAIT_LAST = LW'(ROM_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SCALE,
        SEND,
        HOLD
    } state_t;

    logic [TW-1:0] tickCnt;
    logic          tick;

    logic [PW-1:0] pattern;
    logic [SW-1:0] step;
    logic [2:0]    brightness;
    logic          paused;
    logic          direction;

    state_t        state;
    logic [PW-1:0] patSnap;
    logic [2:0]    brightSnap;
    logic [CW-1:0] shift;
    logic [CW-1:0] colour;
    logic [UW-1:0] unit;
    logic [LW-1:0] waitCnt;
    logic          pending;
    logic          holdFirst;

    assign tick            = (tickCnt == TICK_LAST);
    assign pausedOUT       = paused;
    assign patternIndexOUT = pattern;

    function automatic logic [7:0] scaleByte(input logic [7:0] c,
                                             input logic [2:0] b);
        logic [10:0] prod;
        prod = 11'(c) * (11'(b) + 11'd1);
        return prod[10:3];
    endfunction

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN)
            tickCnt <= '0;
        else if (tick)
            tickCnt <= '0;
        else
            tickCnt <= tickCnt + TW'(1);
    end

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            pattern    <= '0;
            step       <= STEP_MIN;
            brightness <= 3'd7;
            paused     <= 1'b0;
            direction  <= 1'b0;
        end else if (cmdValidIN) begin
            unique case (cmdIN)
                3'd0: paused    <= !paused;
                3'd1: direction <= !direction;
                3'd2: pattern   <= pattern + PW'(1);
                3'd3: pattern   <= pattern - PW'(1);
                3'd4: if (step != STEP_MAX) step <= step + SW'(1);
                3'd5: if (step != STEP_MIN) step <= step - SW'(1);
                3'd6: if (brightness != 3'd7) brightness <= brightness + 3'd1;
                3'd7: if (brightness != 3'd0) brightness <= brightness - 3'd1;
            endcase
        end
    end

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state          <= IDLE;
            romAddrOUT     <= '0;
            txDataOUT      <= '0;
            txStartOUT     <= 1'b0;
            frameActiveOUT <= 1'b0;
            patSnap        <= '0;
            brightSnap     <= 3'd7;
            shift          <= '0;
            colour         <= '0;
            unit           <= '0;
            waitCnt        <= '0;
            pending        <= 1'b0;
            holdFirst      <= 1'b0;
        end else begin
            if (tick && frameActiveOUT)
                pending <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (tick || pending) begin
                        pending        <= 1'b0;
                        frameActiveOUT <= 1'b1;
                        unit           <= '0;
                        colour         <= '0;
                        patSnap        <= pattern;
                        brightSnap     <= brightness;
                        if (!paused)
                            shift <= direction ? shift + CW'(step)
                                               : shift - CW'(step);
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    romAddrOUT <= {patSnap, colour + shift};
                    waitCnt    <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (waitCnt == WAIT_LAST)
                        state <= SCALE;
                    else
                        waitCnt <= waitCnt + LW'(1);
                end
                // Start is raised together with the data when the link is free.
                SCALE: begin
                    txDataOUT <= {scaleByte(romDataIN[23:16], brightSnap),
                                  scaleByte(romDataIN[15:8], brightSnap),
                                  scaleByte(romDataIN[7:0], brightSnap)};
                    txStartOUT <= !txBusyIN;
                    state      <= SEND;
                end
                SEND: begin
                    if (txStartOUT) begin
                        txStartOUT <= 1'b0;
                        holdFirst  <= 1'b1;
                        state      <= HOLD;
                    end else if (!txBusyIN) begin
                        txStartOUT <= 1'b1;
                    end
                end
                HOLD: begin
                    if (holdFirst) begin
                        holdFirst <= 1'b0;
                    end else if (!txBusyIN) begin
                        unit   <= unit + UW'(1);
                        colour <= colour + CW'(1);
                        if (unit == UNIT_LAST) begin
                            frameActiveOUT <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws_frame_sequencer.sv
// Bench for ws_frame_sequencer: random ROM contents, commands and transmitter
// timing compared against a frame-level reference model.
module tb_ws_frame_sequencer;

    localparam int UNITS  = 3;
    localparam int COLS   = 8;
    localparam int PATS   = 4;
    localparam int LAT    = 1;
    localparam int MAXS   = 4;
    localparam int PERIOD = 200;

    logic        clkIN = 1'b0;
    logic        nResetIN = 1'b0;
    logic        cmdValidIN = 1'b0;
    logic [2:0]  cmdIN = 3'd0;
    logic [4:0]  romAddrOUT;
    logic [23:0] romDataIN;
    logic [23:0] txDataOUT;
    logic        txStartOUT;
    logic        txBusyIN;
    logic        frameActiveOUT;
    logic        pausedOUT;
    logic [1:0]  patternIndexOUT;

    int passCnt = 0;
    int totalCnt = 0;
    int cyc = 0;
    int busyLen = 0;
    int busyCnt = 0;
    int relCyc, prevRise, prevFall;
    int mPat, mShift, mDir, mStep, mBright, mPaused;
    int lastAddr [UNITS];
    logic [23:0] lastData [UNITS];
    logic [23:0] romTable [PATS*COLS];

    ws_frame_sequencer #(
        .CLOCK_SPEED(4000),
        .UPDATES_PER_SECOND(20),
        .UNITS_NUMBER(UNITS),
        .PATTERN_COLORS_NUMBER(COLS),
        .PATTERNS_NUMBER(PATS),
        .ROM_LATENCY(LAT),
        .MAX_STEP(MAXS)
    ) dut (
        .clkIN(clkIN),
        .nResetIN(nResetIN),
        .cmdValidIN(cmdValidIN),
        .cmdIN(cmdIN),
        .romAddrOUT(romAddrOUT),
        .romDataIN(romDataIN),
        .txDataOUT(txDataOUT),
        .txStartOUT(txStartOUT),
        .txBusyIN(txBusyIN),
        .frameActiveOUT(frameActiveOUT),
        .pausedOUT(pausedOUT),
        .patternIndexOUT(patternIndexOUT)
    );

    always #5 clkIN = ~clkIN;

    always @(posedge clkIN) cyc <= cyc + 1;

    always @(posedge clkIN) romDataIN <= romTable[romAddrOUT];

    // Transmitter: busy for busyLen cycles after each start pulse.
    always @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN)
            busyCnt <= 0;
        else if (txStartOUT && busyLen > 0)
            busyCnt <= busyLen;
        else if (busyCnt > 0)
            busyCnt <= busyCnt - 1;
    end

    assign txBusyIN = (busyCnt != 0);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        totalCnt++;
        if (got === exp)
            passCnt++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [23:0] scaleRef(input logic [23:0] c, input int b);
        int hi, mid, lo;
        hi  = int'(c[23:16]) * (b + 1) / 8;
        mid = int'(c[15:8]) * (b + 1) / 8;
        lo  = int'(c[7:0]) * (b + 1) / 8;
        return {8'(hi), 8'(mid), 8'(lo)};
    endfunction

    function automatic int nextTick(input int after);
        int m;
        m = (after - relCyc) / PERIOD + 1;
        return relCyc + m * PERIOD;
    endfunction

    task automatic resetModel();
        mPat = 0; mShift = 0; mDir = 0;
        mStep = 1; mBright = 7; mPaused = 0;
    endtask

    task automatic applyCmd(input int code);
        case (code)
            0: mPaused = 1 - mPaused;
            1: mDir = 1 - mDir;
            2: mPat = (mPat + 1) % PATS;
            3: mPat = (mPat + PATS - 1) % PATS;
            4: mStep = (mStep < MAXS) ? mStep + 1 : MAXS;
            5: mStep = (mStep > 1) ? mStep - 1 : 1;
            6: mBright = (mBright < 7) ? mBright + 1 : 7;
            default: mBright = (mBright > 0) ? mBright - 1 : 0;
        endcase
    endtask

    task automatic issueCmd(input int code);
        cmdValidIN = 1'b1;
        cmdIN = 3'(code);
        @(negedge clkIN);
        cmdValidIN = 1'b0;
        applyCmd(code);
    endtask

    // Command seen by the DUT in the same cycle as the next tick.
    task automatic cmdAtTick(input int code);
        int t;
        t = nextTick(cyc);
        while (cyc < t - 1) @(negedge clkIN);
        cmdValidIN = 1'b1;
        cmdIN = 3'(code);
        @(negedge clkIN);
        cmdValidIN = 1'b0;
    endtask

    task automatic runFrame(input bit deferOn, input int deferCode,
                            input bit midOn, input int midCode);
        int n, k, first, lastPulse, expRise, t, pat, br, sh;
        bit midSent;
        t = nextTick(prevRise);
        expRise = (t <= prevFall) ? prevFall + 1 : t;
        n = 0;
        while (!frameActiveOUT && n < 1000) begin
            @(negedge clkIN);
            n++;
        end
        check("frameRise", frameActiveOUT, 1'b1);
        if (!frameActiveOUT) return;
        check("riseCycle", cyc, expRise);
        if (mPaused == 0)
            mShift = (mDir == 1) ? (mShift + mStep) % COLS
                                 : (mShift + COLS - mStep) % COLS;
        pat = mPat; br = mBright; sh = mShift;
        if (deferOn) applyCmd(deferCode);
        prevRise = cyc;
        for (int u = 0; u < UNITS; u++) begin
            lastAddr[u] = -1;
            lastData[u] = '0;
        end
        k = 0; first = -1; lastPulse = -10; n = 0; midSent = 0;
        while (frameActiveOUT && n < 5000) begin
            cmdValidIN = 1'b0;
            if (txStartOUT) begin
                if (k < UNITS) begin
                    lastAddr[k] = int'(romAddrOUT);
                    lastData[k] = txDataOUT;
                end
                if (k == 0) first = n;
                else check("pulseGap", 32'(n - lastPulse > 2), 1);
                lastPulse = n;
                k++;
                if (midOn && !midSent) begin
                    cmdValidIN = 1'b1;
                    cmdIN = 3'(midCode);
                    applyCmd(midCode);
                    midSent = 1;
                end
            end
            @(negedge clkIN);
            n++;
        end
        cmdValidIN = 1'b0;
        check("frameFall", frameActiveOUT, 1'b0);
        prevFall = cyc;
        check("pulseCount", k, UNITS);
        check("firstLatency", first, LAT + 2);
        for (int u = 0; u < UNITS; u++) begin
            t = pat * COLS + (u + sh) % COLS;
            check($sformatf("addr%0d", u), lastAddr[u], t);
            check($sformatf("data%0d", u), lastData[u], scaleRef(romTable[t], br));
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL timeout: simulation did not finish, got no summary, expected one");
        $fatal(1);
    end

    initial begin
        int n, a, f;
        int saved [UNITS];
        for (int i = 0; i < PATS * COLS; i++) romTable[i] = 24'(i);
        resetModel();
        repeat (3) @(negedge clkIN);
        check("rstAddr", romAddrOUT, 0);
        check("rstData", txDataOUT, 0);
        check("rstStart", txStartOUT, 0);
        check("rstActive", frameActiveOUT, 0);
        check("rstPaused", pausedOUT, 0);
        check("rstPattern", patternIndexOUT, 0);

        nResetIN = 1'b1;
        relCyc = cyc; prevRise = cyc; prevFall = cyc;
        runFrame(0, 0, 0, 0);
        check("firstRiseDelay", prevRise - relCyc, PERIOD);
        check("f1addr0", lastAddr[0], 7);
        check("f1addr1", lastAddr[1], 0);
        check("f1addr2", lastAddr[2], 1);

        issueCmd(0);
        check("pausedOn", pausedOUT, 1'b1);
        runFrame(0, 0, 0, 0);
        for (int u = 0; u < UNITS; u++) saved[u] = lastAddr[u];
        runFrame(0, 0, 0, 0);
        for (int u = 0; u < UNITS; u++)
            check($sformatf("pauseSame%0d", u), lastAddr[u], saved[u]);
        issueCmd(0);
        check("pausedOff", pausedOUT, 1'b0);

        issueCmd(1);
        repeat (5) issueCmd(4);
        runFrame(0, 0, 0, 0);
        a = lastAddr[0];
        runFrame(0, 0, 0, 0);
        check("stepPlus4", (lastAddr[0] - a + COLS) % COLS, 4);

        for (int i = 0; i < PATS * COLS; i++) romTable[i] = 24'hFF8010;
        repeat (8) issueCmd(7);
        runFrame(0, 0, 0, 0);
        check("dimmest", lastData[0], 24'h1F1002);
        repeat (7) issueCmd(6);
        runFrame(0, 0, 0, 0);
        check("brightest", lastData[0], 24'hFF8010);

        for (int i = 0; i < PATS * COLS; i++) romTable[i] = 24'($urandom);
        cmdAtTick(2);
        runFrame(1, 2, 0, 0);
        check("patLiveTick", patternIndexOUT, mPat);
        runFrame(0, 0, 0, 0);
        runFrame(0, 0, 1, 7);
        runFrame(0, 0, 1, 3);
        runFrame(0, 0, 0, 0);

        for (int fr = 0; fr < 12; fr++) begin
            for (int i = 0; i < PATS * COLS; i++) romTable[i] = 24'($urandom);
            busyLen = $urandom_range(0, 4);
            repeat ($urandom_range(0, 3)) issueCmd($urandom_range(0, 7));
            check("pausedLive", pausedOUT, mPaused);
            check("patLive", patternIndexOUT, mPat);
            runFrame(0, 0, 0, 0);
        end

        busyLen = 500;
        runFrame(0, 0, 0, 0);
        f = prevFall;
        busyLen = 0;
        runFrame(0, 0, 0, 0);
        check("pendingRise", prevRise, f + 1);
        runFrame(0, 0, 0, 0);

        busyLen = 500;
        n = 0;
        while (!txStartOUT && n < 1000) begin
            @(negedge clkIN);
            n++;
        end
        check("slowPulse", txStartOUT, 1'b1);
        repeat (10) @(negedge clkIN);
        #2 nResetIN = 1'b0;
        #1;
        check("abortAddr", romAddrOUT, 0);
        check("abortData", txDataOUT, 0);
        check("abortStart", txStartOUT, 0);
        check("abortActive", frameActiveOUT, 0);
        check("abortPaused", pausedOUT, 0);
        check("abortPattern", patternIndexOUT, 0);
        @(negedge clkIN);
        busyLen = 0;
        nResetIN = 1'b1;
        relCyc = cyc; prevRise = cyc; prevFall = cyc;
        resetModel();
        runFrame(0, 0, 0, 0);
        check("postRstAddr0", lastAddr[0], 7);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
